// File: rtl/tmr_irq_arbiter.sv
// Interrupt arbiter for the dual 8-bit timer: latches twelve timer interrupt edges as pending events,
// masks them, and presents one fixed-priority vector at a time over a request/acknowledge handshake.
module tmr_irq_arbiter #(
    parameter int NUM_SRC   = 12,
    parameter int VEC_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   irq_src,
    input  logic                 irq_en_we,
    input  logic [NUM_SRC-1:0]   irq_en_wdata,
    input  logic [NUM_SRC-1:0]   pend_clr,
    input  logic                 irq_ack,
    output logic                 irq_req,
    output logic [VEC_WIDTH-1:0] irq_vec,
    output logic [NUM_SRC-1:0]   pending,
    output logic [NUM_SRC-1:0]   overrun,
    output logic [NUM_SRC-1:0]   irq_en,
    output logic [1:0]           dbg_state
);

    // Handshake: irq_req/irq_vec are held stable while in REQ; an acknowledge is
    // taken only when irq_ack is sampled high in a cycle where irq_req is high.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_SRC-1:0]     r_src_q;
    logic [NUM_SRC-1:0]     r_pending;
    logic [NUM_SRC-1:0]     r_overrun;
    logic [NUM_SRC-1:0]     r_en;
    logic [VEC_WIDTH-1:0]   r_vec;
    logic                   r_req;

    logic [NUM_SRC-1:0]     w_event;
    logic [NUM_SRC-1:0]     w_eligible;
    logic [NUM_SRC-1:0]     w_ack_mask;
    logic [NUM_SRC-1:0]     w_pending_nxt;
    logic [NUM_SRC-1:0]     w_overrun_nxt;
    logic [VEC_WIDTH-1:0]   w_win;
    logic [VEC_WIDTH-1:0]   w_vec_nxt;
    logic                   w_ack_fire;

    // Sampled even during reset so a source already high at release is not an edge.
    always_ff @(posedge clk) begin
        r_src_q <= irq_src;
    end

    assign w_event    = irq_src & ~r_src_q;
    assign w_eligible = r_pending & r_en;
    assign w_ack_fire = (r_state == ST_REQ) && irq_ack;
    assign w_ack_mask = w_ack_fire ? (NUM_SRC'(1) << r_vec) : '0;

    // A new event beats any clear on the same bit and then does not count as lost.
    assign w_pending_nxt = (r_pending & ~pend_clr & ~w_ack_mask) | w_event;
    assign w_overrun_nxt = (r_overrun & ~pend_clr)
                         | (w_event & r_pending & ~pend_clr & ~w_ack_mask);

    always_comb begin
        w_win = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_win = VEC_WIDTH'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        case (r_state)
            ST_IDLE: begin
                if (|w_eligible) begin
                    w_vec_nxt   = w_win;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    w_state_nxt = ST_GAP;
                end else if (!w_eligible[r_vec]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_vec     <= '0;
            r_req     <= 1'b0;
            r_pending <= '0;
            r_overrun <= '0;
            r_en      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_vec     <= w_vec_nxt;
            r_req     <= (w_state_nxt == ST_REQ);
            r_pending <= w_pending_nxt;
            r_overrun <= w_overrun_nxt;
            if (irq_en_we) begin
                r_en <= irq_en_wdata;
            end
        end
    end

    assign irq_req   = r_req;
    assign irq_vec   = r_vec;
    assign pending   = r_pending;
    assign overrun   = r_overrun;
    assign irq_en    = r_en;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_tmr_irq_arbiter.sv
// Self-checking bench for tmr_irq_arbiter: a vector table plus hand-written corner sequences,
// with every expected output set pushed into a queue when driven and popped after the clock edge.
module tb_tmr_irq_arbiter;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam int         EW     = 43;

  typedef struct {
    logic        rst;
    logic [11:0] src;
    logic        we;
    logic [11:0] wdata;
    logic [11:0] clr;
    logic        ack;
    logic        req;
    logic [3:0]  vec;
    logic [11:0] pend;
    logic [11:0] ovr;
    logic [11:0] en;
    logic [1:0]  st;
  } vec_t;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] irq_src = '0;
  logic        irq_en_we = 1'b0;
  logic [11:0] irq_en_wdata = '0;
  logic [11:0] pend_clr = '0;
  logic        irq_ack = 1'b0;
  logic        irq_req;
  logic [3:0]  irq_vec;
  logic [11:0] pending;
  logic [11:0] overrun;
  logic [11:0] irq_en;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  tmr_irq_arbiter #(.NUM_SRC(12), .VEC_WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_src      (irq_src),
    .irq_en_we    (irq_en_we),
    .irq_en_wdata (irq_en_wdata),
    .pend_clr     (pend_clr),
    .irq_ack      (irq_ack),
    .irq_req      (irq_req),
    .irq_vec      (irq_vec),
    .pending      (pending),
    .overrun      (overrun),
    .irq_en       (irq_en),
    .dbg_state    (dbg_state)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  vec_t          tbl[24];

  function automatic vec_t mk(input logic r, input logic [11:0] s, input logic w,
                              input logic [11:0] wd, input logic [11:0] c, input logic a,
                              input logic q, input logic [3:0] v, input logic [11:0] p,
                              input logic [11:0] o, input logic [11:0] e, input logic [1:0] st);
    vec_t t;
    t.rst = r; t.src = s; t.we = w; t.wdata = wd; t.clr = c; t.ack = a;
    t.req = q; t.vec = v; t.pend = p; t.ovr = o; t.en = e; t.st = st;
    return t;
  endfunction

  // driver: inputs change at the falling edge, outputs are checked 1 time unit after the rising edge
  task automatic apply(input string tag, input vec_t v);
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    @(negedge clk);
    rst          = v.rst;
    irq_src      = v.src;
    irq_en_we    = v.we;
    irq_en_wdata = v.wdata;
    pend_clr     = v.clr;
    irq_ack      = v.ack;
    exp_q.push_back({v.req, v.vec, v.pend, v.ovr, v.en, v.st});
    @(posedge clk);
    #1;
    got = {irq_req, irq_vec, pending, overrun, irq_en, dbg_state};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard queue empty, got %011h", tag, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got req=%0d vec=%0d pend=%03h ovr=%03h en=%03h st=%0d, expected req=%0d vec=%0d pend=%03h ovr=%03h en=%03h st=%0d",
                 tag, got[42], got[41:38], got[37:26], got[25:14], got[13:2], got[1:0],
                 exp[42], exp[41:38], exp[37:26], exp[25:14], exp[13:2], exp[1:0]);
      end
    end
  endtask

  initial begin
    // reset with all sources high, OVI0 request/ack, frozen vector, masking
    //            rst src    we wdata  clr    ack req vec pend    ovr     en      st
    tbl[0]  = mk(1, 12'hFFF, 0, 12'h000, 12'h000, 0, 0, 0,  12'h000, 12'h000, 12'h000, S_IDLE);
    tbl[1]  = mk(0, 12'hFFF, 1, 12'hFFF, 12'h000, 0, 0, 0,  12'h000, 12'h000, 12'hFFF, S_IDLE);
    tbl[2]  = mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 0, 0,  12'h000, 12'h000, 12'hFFF, S_IDLE);
    tbl[3]  = mk(0, 12'h004, 0, 12'h000, 12'h000, 0, 0, 0,  12'h004, 12'h000, 12'hFFF, S_IDLE);
    tbl[4]  = mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 1, 2,  12'h004, 12'h000, 12'hFFF, S_REQ);
    tbl[5]  = mk(0, 12'h000, 0, 12'h000, 12'h000, 1, 0, 2,  12'h000, 12'h000, 12'hFFF, S_GAP);
    tbl[6]  = mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 0, 2,  12'h000, 12'h000, 12'hFFF, S_IDLE);
    tbl[7]  = mk(0, 12'h020, 0, 12'h000, 12'h000, 0, 0, 2,  12'h020, 12'h000, 12'hFFF, S_IDLE);
    tbl[8]  = mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 1, 5,  12'h020, 12'h000, 12'hFFF, S_REQ);
    tbl[9]  = mk(0, 12'h001, 0, 12'h000, 12'h000, 0, 1, 5,  12'h021, 12'h000, 12'hFFF, S_REQ);
    tbl[10] = mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 1, 5,  12'h021, 12'h000, 12'hFFF, S_REQ);
    tbl[11] = mk(0, 12'h000, 0, 12'h000, 12'h000, 1, 0, 5,  12'h001, 12'h000, 12'hFFF, S_GAP);
    tbl[12] = mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 0, 5,  12'h001, 12'h000, 12'hFFF, S_IDLE);
    tbl[13] = mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 1, 0,  12'h001, 12'h000, 12'hFFF, S_REQ);
    tbl[14] = mk(0, 12'h000, 0, 12'h000, 12'h000, 1, 0, 0,  12'h000, 12'h000, 12'hFFF, S_GAP);
    tbl[15] = mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 0, 0,  12'h000, 12'h000, 12'hFFF, S_IDLE);
    tbl[16] = mk(0, 12'h000, 1, 12'h000, 12'h000, 0, 0, 0,  12'h000, 12'h000, 12'h000, S_IDLE);
    tbl[17] = mk(0, 12'h400, 0, 12'h000, 12'h000, 0, 0, 0,  12'h400, 12'h000, 12'h000, S_IDLE);
    tbl[18] = mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 0, 0,  12'h400, 12'h000, 12'h000, S_IDLE);
    tbl[19] = mk(0, 12'h000, 0, 12'h000, 12'h000, 1, 0, 0,  12'h400, 12'h000, 12'h000, S_IDLE);
    tbl[20] = mk(0, 12'h000, 1, 12'h400, 12'h000, 0, 0, 0,  12'h400, 12'h000, 12'h400, S_IDLE);
    tbl[21] = mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 1, 10, 12'h400, 12'h000, 12'h400, S_REQ);
    tbl[22] = mk(0, 12'h000, 0, 12'h000, 12'h000, 1, 0, 10, 12'h000, 12'h000, 12'h400, S_GAP);
    tbl[23] = mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 0, 10, 12'h000, 12'h000, 12'h400, S_IDLE);

    for (int i = 0; i < 24; i++) begin
      apply($sformatf("tbl%0d", i), tbl[i]);
    end

    // overrun on src[7], then event coinciding with its ack
    apply("ovr_en",    mk(0, 12'h000, 1, 12'hFFF, 12'h000, 0, 0, 10, 12'h000, 12'h000, 12'hFFF, S_IDLE));
    apply("ovr_ev1",   mk(0, 12'h080, 0, 12'h000, 12'h000, 0, 0, 10, 12'h080, 12'h000, 12'hFFF, S_IDLE));
    apply("ovr_req",   mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 1, 7,  12'h080, 12'h000, 12'hFFF, S_REQ));
    apply("ovr_ev2",   mk(0, 12'h080, 0, 12'h000, 12'h000, 0, 1, 7,  12'h080, 12'h080, 12'hFFF, S_REQ));
    apply("ovr_ack",   mk(0, 12'h000, 0, 12'h000, 12'h000, 1, 0, 7,  12'h000, 12'h080, 12'hFFF, S_GAP));
    apply("ovr_clr",   mk(0, 12'h000, 0, 12'h000, 12'h080, 0, 0, 7,  12'h000, 12'h000, 12'hFFF, S_IDLE));
    apply("sim_ev1",   mk(0, 12'h080, 0, 12'h000, 12'h000, 0, 0, 7,  12'h080, 12'h000, 12'hFFF, S_IDLE));
    apply("sim_req",   mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 1, 7,  12'h080, 12'h000, 12'hFFF, S_REQ));
    apply("sim_evack", mk(0, 12'h080, 0, 12'h000, 12'h000, 1, 0, 7,  12'h080, 12'h000, 12'hFFF, S_GAP));
    apply("sim_idle",  mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 0, 7,  12'h080, 12'h000, 12'hFFF, S_IDLE));
    apply("sim_rereq", mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 1, 7,  12'h080, 12'h000, 12'hFFF, S_REQ));
    apply("sim_ack",   mk(0, 12'h000, 0, 12'h000, 12'h000, 1, 0, 7,  12'h000, 12'h000, 12'hFFF, S_GAP));
    apply("sim_end",   mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 0, 7,  12'h000, 12'h000, 12'hFFF, S_IDLE));

    // withdraw by pend_clr, then by mask clear
    apply("wd_ev",     mk(0, 12'h008, 0, 12'h000, 12'h000, 0, 0, 7,  12'h008, 12'h000, 12'hFFF, S_IDLE));
    apply("wd_req",    mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 1, 3,  12'h008, 12'h000, 12'hFFF, S_REQ));
    apply("wd_clr",    mk(0, 12'h000, 0, 12'h000, 12'h008, 0, 1, 3,  12'h000, 12'h000, 12'hFFF, S_REQ));
    apply("wd_drop",   mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 0, 3,  12'h000, 12'h000, 12'hFFF, S_IDLE));
    apply("wm_ev",     mk(0, 12'h008, 0, 12'h000, 12'h000, 0, 0, 3,  12'h008, 12'h000, 12'hFFF, S_IDLE));
    apply("wm_req",    mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 1, 3,  12'h008, 12'h000, 12'hFFF, S_REQ));
    apply("wm_mask",   mk(0, 12'h000, 1, 12'hFF7, 12'h000, 0, 1, 3,  12'h008, 12'h000, 12'hFF7, S_REQ));
    apply("wm_drop",   mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 0, 3,  12'h008, 12'h000, 12'hFF7, S_IDLE));
    apply("wm_hold",   mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 0, 3,  12'h008, 12'h000, 12'hFF7, S_IDLE));

    // reset in REQ with overrun set, then a late ack
    apply("rs_unmask", mk(0, 12'h000, 1, 12'hFFF, 12'h000, 0, 0, 3,  12'h008, 12'h000, 12'hFFF, S_IDLE));
    apply("rs_req",    mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 1, 3,  12'h008, 12'h000, 12'hFFF, S_REQ));
    apply("rs_ovr",    mk(0, 12'h008, 0, 12'h000, 12'h000, 0, 1, 3,  12'h008, 12'h008, 12'hFFF, S_REQ));
    apply("rs_rst",    mk(1, 12'h000, 0, 12'h000, 12'h000, 0, 0, 0,  12'h000, 12'h000, 12'h000, S_IDLE));
    apply("rs_lateack",mk(0, 12'h000, 0, 12'h000, 12'h000, 1, 0, 0,  12'h000, 12'h000, 12'h000, S_IDLE));
    apply("rs_quiet",  mk(0, 12'h000, 0, 12'h000, 12'h000, 0, 0, 0,  12'h000, 12'h000, 12'h000, S_IDLE));

    // final report
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
